// File: rtl/seven_seg_scan_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_bcd_if
//  Description : Display bus between a value source and the seven-segment
//                scanner: binary value in, segment/anode/status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_bcd_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 4
);
    logic [IN_W-1:0]   inp;
    logic [6:0]        led;
    logic [DIGITS-1:0] an;
    logic              busy;
    logic              ovf;

    // Value source side
    modport master (output inp, input led, an, busy, ovf);
    // Display driver side
    modport slave  (input inp, output led, an, busy, ovf);
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_bcd
//  Description : Multiplexed common-anode seven-segment driver. Binary input
//                is converted to BCD by a sequential double-dabble engine
//                (one shift per clock) and committed atomically to a display
//                register that is scanned one digit per prescaler slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_bcd #(
    parameter int IN_W     = 8,
    parameter int DIGITS   = 4,
    parameter int DIV      = 1025,
    parameter int BLANK_LZ = 1
) (
    input  wire                   clk,
    input  wire                   rst_n,
    seven_seg_scan_bcd_if.slave   bus
);

    // 10^n as a 64-bit constant, wide enough for every legal DIGITS
    function automatic logic [63:0] f_pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) v = v * 64'd10;
        return v;
    endfunction

    localparam int          c_SCR_W  = (DIGITS + 1) * 4;
    localparam int          c_DISP_W = DIGITS * 4;
    localparam int          c_PRE_W  = $clog2(DIV);
    localparam int          c_SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          c_CNT_W  = $clog2(IN_W + 1);
    localparam logic [63:0] c_LIMIT  = f_pow10(DIGITS);
    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(DIGITS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(IN_W - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_load;
    logic                w_shift;
    logic                w_commit;

    logic [IN_W-1:0]     r_cap;
    logic [IN_W-1:0]     r_sh;
    logic [c_SCR_W-1:0]  r_scr;
    logic [c_SCR_W-1:0]  w_adj;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_DISP_W-1:0] r_disp;
    logic                r_ovf;
    logic                r_busy;
    logic                w_over;

    logic [c_PRE_W-1:0]  r_presc;
    logic                w_tick;
    logic [c_SCAN_W-1:0] r_scan;
    logic [DIGITS-1:0]   w_nz;
    logic                w_upper_nz;
    logic [3:0]          w_digit;
    logic [6:0]          w_seg;
    logic [6:0]          r_led;
    logic [DIGITS-1:0]   r_an;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: restart whenever the input differs from the last capture
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (bus.inp != r_cap) w_state_nxt = c_SHIFT;
            c_SHIFT:  if (r_cnt == c_CNT_LAST) w_state_nxt = c_COMMIT;
            c_COMMIT: w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes
    always_comb begin
        w_load   = (r_state == c_IDLE) && (bus.inp != r_cap);
        w_shift  = (r_state == c_SHIFT);
        w_commit = (r_state == c_COMMIT);
    end

    // Double-dabble correction: every scratch nibble >= 5 gets +3 before the shift
    generate
        for (genvar k = 0; k <= DIGITS; k++) begin : g_adj
            assign w_adj[k*4 +: 4] = (r_scr[k*4 +: 4] >= 4'd5) ?
                                     (r_scr[k*4 +: 4] + 4'd3) : r_scr[k*4 +: 4];
        end
    endgenerate

    assign w_over = ({{(64-IN_W){1'b0}}, r_cap} >= c_LIMIT);

    // Conversion datapath; display and ovf change only in COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap  <= '0;
            r_sh   <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            if (w_load) begin
                r_cap  <= bus.inp;
                r_sh   <= bus.inp;
                r_scr  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end
            if (w_shift) begin
                {r_scr, r_sh} <= {w_adj, r_sh} << 1;
                r_cnt         <= r_cnt + c_CNT_W'(1);
            end
            if (w_commit) begin
                r_disp <= r_scr[c_DISP_W-1:0];
                r_ovf  <= w_over;
                r_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan
    // ------------------------------------------------------------------

    assign w_tick = (r_presc == c_PRE_LAST);

    // Prescaler and digit index; index advances once per slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_scan  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PRE_W'(1);
            if (w_tick) r_scan <= (r_scan == c_SCAN_LAST) ? '0 : r_scan + c_SCAN_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_nz
            assign w_nz[k] = (r_disp[k*4 +: 4] != 4'd0);
        end
    endgenerate

    // Any non-zero digit at or above the scanned position keeps it visible
    assign w_upper_nz = |(w_nz >> r_scan);

    // Select the scanned digit and encode it (dash on overflow, blank for leading zeros)
    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scan == c_SCAN_W'(k)) w_digit = r_disp[k*4 +: 4];
        end
        case (w_digit)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
        if (r_ovf)
            w_seg = 7'b0111111;
        else if ((BLANK_LZ != 0) && (r_scan != '0) && !w_upper_nz)
            w_seg = 7'b1111111;
    end

    // Registered segment and anode drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 7'h7F;
            r_an  <= '1;
        end else begin
            r_led <= w_seg;
            r_an  <= ~(DIGITS'(1) << r_scan);
        end
    end

    assign bus.led  = r_led;
    assign bus.an   = r_an;
    assign bus.busy = r_busy;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_bcd
//  Description : Self-checking bench for seven_seg_scan_bcd. Three instances
//                (4 digits blanked, 4 digits unblanked, 2 digits blanked)
//                share clock, reset and input value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_bcd;

    localparam int IN_W = 8;
    localparam int DIV  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;
    int   prev;

    seven_seg_scan_bcd_if #(.IN_W(IN_W), .DIGITS(4)) ifa ();
    seven_seg_scan_bcd_if #(.IN_W(IN_W), .DIGITS(4)) ifb ();
    seven_seg_scan_bcd_if #(.IN_W(IN_W), .DIGITS(2)) ifc ();

    seven_seg_scan_bcd #(.IN_W(IN_W), .DIGITS(4), .DIV(DIV), .BLANK_LZ(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    seven_seg_scan_bcd #(.IN_W(IN_W), .DIGITS(4), .DIV(DIV), .BLANK_LZ(0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    seven_seg_scan_bcd #(.IN_W(IN_W), .DIGITS(2), .DIV(DIV), .BLANK_LZ(1))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    always #5 clk = ~clk;

    // Clock edges seen since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int pow10(input int n);
        int v = 1;
        for (int i = 0; i < n; i++) v = v * 10;
        return v;
    endfunction

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    // What digit position k of a display of 'nd' digits should show for value 'val'
    function automatic logic [6:0] exp_led(input int val, input int k, input int nd, input bit blank);
        if (val >= pow10(nd))                 return 7'b0111111;
        if (blank && k > 0 && val < pow10(k)) return 7'b1111111;
        return seg((val / pow10(k)) % 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_inp(input int v);
        ifa.inp = IN_W'(v);
        ifb.inp = IN_W'(v);
        ifc.inp = IN_W'(v);
    endtask

    task automatic check_reset_outputs();
        chk("rst_led_a", 32'(ifa.led), 32'h7F);
        chk("rst_an_a",  32'(ifa.an),  32'hF);
        chk("rst_busy_a", 32'(ifa.busy), 32'd0);
        chk("rst_ovf_a", 32'(ifa.ovf), 32'd0);
        chk("rst_led_c", 32'(ifc.led), 32'h7F);
        chk("rst_an_c",  32'(ifc.an),  32'h3);
    endtask

    // One sample point: busy, scanned anode and segments of every instance
    task automatic check_now(input bit eb, input int dval, input int oval);
        int ia, ic;
        logic [3:0] ea;
        logic [1:0] ec;
        ia = ((cyc - 1) / DIV) % 4;
        ic = ((cyc - 1) / DIV) % 2;
        ea = ~(4'(1) << ia);
        ec = ~(2'(1) << ic);
        chk("busy_a", 32'(ifa.busy), 32'(eb));
        chk("busy_c", 32'(ifc.busy), 32'(eb));
        chk("an_a",   32'(ifa.an),   32'(ea));
        chk("an_b",   32'(ifb.an),   32'(ea));
        chk("an_c",   32'(ifc.an),   32'(ec));
        chk("led_a",  32'(ifa.led),  32'(exp_led(dval, ia, 4, 1'b1)));
        chk("led_b",  32'(ifb.led),  32'(exp_led(dval, ia, 4, 1'b0)));
        chk("led_c",  32'(ifc.led),  32'(exp_led(dval, ic, 2, 1'b1)));
        chk("ovf_a",  32'(ifa.ovf),  32'(oval >= 10000));
        chk("ovf_c",  32'(ifc.ovf),  32'(oval >= 100));
    endtask

    // Apply v while 'old' is on display; conversion commits IN_W+2 edges later,
    // and the registered segments follow one edge after that
    task automatic run_value(input int v, input int old, input int ncyc);
        bit conv;
        conv = (v != old);
        set_inp(v);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            check_now(conv && k <= IN_W + 1,
                      (conv && k >= IN_W + 3) ? v : old,
                      (conv && k >= IN_W + 2) ? v : old);
        end
    endtask

    initial begin
        int dirs [6] = '{5, 100, 99, 0, 255, 10};
        int v;

        // Reset held with a non-zero input
        set_inp(123);
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        run_value(123, 0, IN_W + 2 + 4 * DIV);
        prev = 123;

        // Directed: blanking, overflow boundary, zero, full scale
        foreach (dirs[i]) begin
            run_value(dirs[i], prev, IN_W + 2 + 4 * DIV);
            prev = dirs[i];
        end

        // Input changes during SHIFT: first commit 200, then 37 with no intermediate
        set_inp(200);
        for (int k = 1; k <= 2 * IN_W + 4 + 4 * DIV; k++) begin
            @(negedge clk);
            check_now((k <= IN_W + 1) || (k >= IN_W + 3 && k <= 2 * IN_W + 3),
                      (k <= IN_W + 2) ? prev : ((k <= 2 * IN_W + 4) ? 200 : 37),
                      (k <= IN_W + 1) ? prev : ((k <= 2 * IN_W + 3) ? 200 : 37));
            if (k == 3) set_inp(37);
        end
        prev = 37;

        // Random values
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 255));
            run_value(v, prev, IN_W + 2 + 4 * DIV);
            prev = v;
        end

        // Asynchronous reset in the middle of a conversion
        v = (prev == 77) ? 78 : 77;
        set_inp(v);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        run_value(v, 0, IN_W + 2 + 4 * DIV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_bcd.md
Name: seven_seg_scan_bcd

Overview:
Parametrised multiplexed seven-segment driver for the board display. It converts an unsigned binary input to BCD with a sequential double-dabble engine, one shift per clock. It then time-multiplexes DIGITS common-anode digits at a prescaled scan rate. Versus the previous generation it adds configurable width, digit count and scan rate, leading-zero blanking, overflow indication, and atomic display update.

Parameters:
IN_W, 8, width of binary input (1..20)
DIGITS, 4, number of displayed digits (1..6)
DIV, 1025, clk cycles per scan slot (>=2)
BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
inp  in  IN_W  unsigned value to display, sampled every cycle
led  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  DIGITS  digit enables, active-low; an[0] = least-significant (rightmost)
busy  out  1  conversion in progress
ovf  out  1  displayed value exceeds 10^DIGITS-1

Behaviour:
- Reset (async, rst_n=0): led=7'h7F, an=all 1, busy=0, ovf=0. Prescaler=0, scan index=0, display BCD=0, captured value=0, FSM=IDLE.
- Prescaler: counts 0..DIV-1 and wraps. tick=1 for one clk when count==DIV-1.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: if inp != captured, latch captured<=inp, clear the BCD scratch, load shift reg with inp, busy<=1, go to SHIFT.
  - SHIFT: IN_W cycles. Each cycle: add 3 to every scratch nibble >=5, then shift {scratch,shiftreg} left by 1. Scratch holds DIGITS+1 nibbles.
  - COMMIT: one cycle. Display BCD<=low DIGITS nibbles. ovf<=(captured >= 10^DIGITS). busy<=0. Go to IDLE.
  - Latency from inp change to display register update is IN_W+2 clk.
  - The display register changes only in COMMIT, so there are no partial values.
- inp changing during SHIFT is ignored until IDLE. The completed conversion reflects the latched value; the IDLE compare then restarts immediately.
- Scan: on tick, scan index increments and wraps DIGITS-1 -> 0. led and an are registered and update on the clk after the tick, with exactly one an bit low.
- Segment code (led, active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD nibble=1111111.
- Leading-zero blanking (BLANK_LZ=1): digit k>0 drives led=1111111 if it and all higher digits are 0. Digit 0 is never blanked. Its an bit still cycles normally.
- Overflow (ovf=1): every digit drives 0111111 (dash), overriding blanking.
- Reset mid-conversion: aborts to IDLE with the display at 0. If inp!=0, a conversion starts on the first clk after release.

Test Plan:
1. Reset: hold rst_n=0 with inp=8'd123 -> led=7'h7F, an=4'hF, busy=0. After release, busy=1 for exactly 8 SHIFT cycles plus COMMIT (10 clk from release to display update).
2. Scan order (DIV=4, inp=123): an cycles 1110,1101,1011,0111, changing every 4 clk. led shows 0110000,0100100,1111001,1111111 (digit 3 blanked).
3. Blanking: inp=5 -> only an[0] slot shows 0010010. BLANK_LZ=0 with inp=5 -> digits 3..1 show 1000000.
4. Mid-conversion change: inp 200->37 on 3rd SHIFT cycle -> display commits 200, busy drops for one cycle, then reasserts. Display commits 37 at IN_W+2 clk later, with no intermediate value.
5. Overflow (IN_W=8, DIGITS=2): inp=100 -> ovf=1, both slots show 0111111. inp=99 -> ovf=0, shows 9,9.
6. Reset mid-operation: assert rst_n during SHIFT and during a scan slot -> outputs go to reset values asynchronously. After release, the display restarts at index 0 with a fresh conversion.
